// File: rtl/hilo_md_ctrl.sv
// HI/LO sequencer: iterative mult/div plus single-cycle MTHI/MTLO writes.
module hilo_md_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic [WIDTH-1:0] hi_cur,
   input  logic [WIDTH-1:0] lo_cur,
   input  logic             flush,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             stall,
   output logic             busy
);

   localparam int unsigned DW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state, state_nxt;
   logic [DW-1:0]    acc;
   logic [WIDTH-1:0] b_r;
   logic [CW-1:0]    cnt;
   logic             neg_lo, neg_hi;
   logic [WIDTH-1:0] hi_r, lo_r;

   logic             is_md, op_div, op_signed, rs_neg, rt_neg, div_zero, accept, last;
   logic [WIDTH-1:0] rs_abs, rt_abs;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic [DW-1:0]    mul_nxt, div_nxt, prod_fix;
   logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;

   // Instruction decode and operand conditioning
   always_comb begin
      is_md     = valid && (op >= 3'd1) && (op <= 3'd4);
      op_div    = (op == 3'd3) || (op == 3'd4);
      op_signed = (op == 3'd1) || (op == 3'd3);
      rs_neg    = op_signed && rs_data[WIDTH-1];
      rt_neg    = op_signed && rt_data[WIDTH-1];
      rs_abs    = rs_neg ? (WIDTH'(0) - rs_data) : rs_data;
      rt_abs    = rt_neg ? (WIDTH'(0) - rt_data) : rt_data;
      div_zero  = op_div && (rt_data == '0);
      accept    = rst && (state == IDLE) && is_md && !flush;
      last      = (cnt == CW'(WIDTH - 1));
   end

   // One shift-add / restoring-subtract step and the sign-fixed final results
   always_comb begin
      mul_sum  = {1'b0, acc[DW-1:WIDTH]} + {1'b0, (acc[0] ? b_r : WIDTH'(0))};
      mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
      div_sh   = {acc[DW-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_r};
      if (div_diff[WIDTH])
         div_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      prod_fix = neg_lo ? (DW'(0) - mul_nxt) : mul_nxt;
      quo      = div_nxt[WIDTH-1:0];
      rem      = div_nxt[DW-1:WIDTH];
      quo_fix  = neg_lo ? (WIDTH'(0) - quo) : quo;
      rem_fix  = neg_hi ? (WIDTH'(0) - rem) : rem;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Datapath registers: operand latch, iteration, result capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc    <= '0;
         b_r    <= '0;
         cnt    <= '0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else if (accept) begin
         cnt    <= '0;
         neg_lo <= rs_neg ^ rt_neg;
         neg_hi <= rs_neg;
         if (op_div) begin
            acc <= {WIDTH'(0), rs_abs};
            b_r <= rt_abs;
            if (div_zero) begin
               hi_r <= rs_data;
               lo_r <= '1;
            end
         end else begin
            acc <= {WIDTH'(0), rt_abs};
            b_r <= rs_abs;
         end
      end else if (!flush && state == MUL) begin
         acc <= mul_nxt;
         cnt <= cnt + CW'(1);
         if (last) {hi_r, lo_r} <= prod_fix;
      end else if (!flush && state == DIV) begin
         acc <= div_nxt;
         cnt <= cnt + CW'(1);
         if (last) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
         end
      end
   end

   // Next-state logic; flush returns to IDLE from anywhere
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (is_md) state_nxt = div_zero ? DONE : (op_div ? DIV : MUL);
            MUL:  if (last) state_nxt = DONE;
            DIV:  if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs; IDLE-state terms are gated by rst so reset forces them low at once
   always_comb begin
      hilo_we = 1'b0;
      stall   = 1'b0;
      hi_o    = hi_r;
      lo_o    = lo_r;
      busy    = (state != IDLE);
      case (state)
         IDLE: begin
            if (rst && valid && !flush) begin
               if (is_md) begin
                  stall = 1'b1;
               end else if (op == 3'd5) begin
                  hilo_we = 1'b1;
                  hi_o    = rs_data;
                  lo_o    = lo_cur;
               end else if (op == 3'd6) begin
                  hilo_we = 1'b1;
                  hi_o    = hi_cur;
                  lo_o    = rs_data;
               end
            end
         end
         MUL, DIV: stall = !flush;
         DONE:     hilo_we = !flush;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: transaction-level reference model plus directed cases.
module tb_hilo_md_ctrl;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] rs_data = '0, rt_data = '0, hi_cur = '0, lo_cur = '0;
   logic         flush = 1'b0;
   logic         hilo_we, stall, busy;
   logic [W-1:0] hi_o, lo_o;

   hilo_md_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .valid(valid), .op(op), .rs_data(rs_data), .rt_data(rt_data),
      .hi_cur(hi_cur), .lo_cur(lo_cur), .flush(flush), .hilo_we(hilo_we), .hi_o(hi_o),
      .lo_o(lo_o), .stall(stall), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0;

   // model state: one outstanding iterative op and the cycle its result is written
   bit          pending = 1'b0;
   int          wcyc = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   // observed writes, for the directed cases
   int          we_cnt = 0, last_we_cyc = -1;
   logic [31:0] last_hi = '0, last_lo = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural HI/LO result as {hi, lo}
   function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint pa, pb;
      int     sa, sb;
      case (o)
         3'd1: begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            return 64'(pa * pb);
         end
         3'd2: return {32'd0, a} * {32'd0, b};
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
         end
         3'd4: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Per-cycle comparison against the model, then advance the model across the coming edge
   always @(negedge clk) begin : compare
      logic        e_we, e_stall, e_busy;
      logic [31:0] e_hi, e_lo;
      logic [63:0] r;
      e_we = 1'b0; e_stall = 1'b0; e_busy = 1'b0; e_hi = '0; e_lo = '0;
      if (!rst) begin
         pending = 1'b0;
         chk("rst_we", 64'(hilo_we), 64'd0);
         chk("rst_stall", 64'(stall), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_hi", 64'(hi_o), 64'd0);
         chk("rst_lo", 64'(lo_o), 64'd0);
      end else begin
         e_busy = pending;
         if (pending && cyc == wcyc) begin
            e_we = !flush; e_hi = m_hi; e_lo = m_lo;
         end else if (pending) begin
            e_stall = !flush;
         end else if (valid && !flush) begin
            if (op >= 3'd1 && op <= 3'd4) e_stall = 1'b1;
            else if (op == 3'd5) begin e_we = 1'b1; e_hi = rs_data; e_lo = lo_cur; end
            else if (op == 3'd6) begin e_we = 1'b1; e_hi = hi_cur;  e_lo = rs_data; end
         end
         chk("we", 64'(hilo_we), 64'(e_we));
         chk("stall", 64'(stall), 64'(e_stall));
         chk("busy", 64'(busy), 64'(e_busy));
         if (e_we) begin
            chk("hi", 64'(hi_o), 64'(e_hi));
            chk("lo", 64'(lo_o), 64'(e_lo));
         end
         if (flush) pending = 1'b0;
         else if (pending && cyc == wcyc) pending = 1'b0;
         else if (!pending && valid && op >= 3'd1 && op <= 3'd4) begin
            pending = 1'b1;
            wcyc = cyc + ((op >= 3'd3 && rt_data == 32'd0) ? 1 : W + 1);
            r = ref_res(op, rs_data, rt_data);
            m_hi = r[63:32];
            m_lo = r[31:0];
         end
      end
      if (hilo_we) begin
         we_cnt++;
         last_we_cyc = cyc;
         last_hi = hi_o;
         last_lo = lo_o;
      end
      cyc++;
   end

   task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      valid = v; op = o; rs_data = a; rt_data = b; flush = 1'b0;
   endtask

   // Issue one op, wait (bounded) for its write, check latency and values against literals
   task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat);
      int t, n0;
      chk({nm, "_model"}, ref_res(o, a, b), {ehi, elo});
      n0 = we_cnt;
      drive(1'b1, o, a, b);
      t = cyc;
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      for (int i = 0; i < lat + 5 && we_cnt == n0; i++) @(posedge clk);
      #1;
      chk({nm, "_latency"}, 64'(last_we_cyc - t), 64'(lat));
      chk({nm, "_result"}, {last_hi, last_lo}, {ehi, elo});
      chk({nm, "_writes"}, 64'(we_cnt - n0), 64'd1);
   endtask

   initial begin : stim
      int n0;
      #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);

      // MTHI / MTLO: same-cycle combinational write
      #1; valid = 1'b1; op = 3'd5; rs_data = 32'h1234; lo_cur = 32'hABCD; hi_cur = 32'h5555;
      #1;
      chk("mthi_we", 64'(hilo_we), 64'd1);
      chk("mthi_data", {hi_o, lo_o}, {32'h1234, 32'hABCD});
      chk("mthi_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      op = 3'd6; rs_data = 32'h9999; hi_cur = 32'h7777; lo_cur = 32'h1111;
      #1;
      chk("mtlo_we", 64'(hilo_we), 64'd1);
      chk("mtlo_data", {hi_o, lo_o}, {32'h7777, 32'h9999});
      chk("mtlo_stall", 64'(stall), 64'd0);
      @(posedge clk); #1; valid = 1'b0; op = 3'd0;

      do_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
      do_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
      do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
      do_op("divu_zero", 3'd4, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1);
      do_op("divu_mix", 3'd4, 32'd1000, 32'd7, 32'd6, 32'd142, 33);

      // flush at T+10 of a mult: no write afterwards, IDLE at T+11
      n0 = we_cnt;
      drive(1'b1, 3'd1, 32'd7, 32'd9);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (8) @(posedge clk);
      #1; flush = 1'b1;
      #1;
      chk("flush_stall", 64'(stall), 64'd0);
      chk("flush_we", 64'(hilo_we), 64'd0);
      @(posedge clk); #1; flush = 1'b0;
      #1;
      chk("flush_idle", 64'(busy), 64'd0);
      repeat (40) @(posedge clk);
      chk("flush_no_write", 64'(we_cnt - n0), 64'd0);

      // asynchronous reset at T+5 of a div, with a live mult presented
      drive(1'b1, 3'd3, 32'd1000, 32'd7);
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1; valid = 1'b1; op = 3'd1;
      #1; rst = 1'b0;
      #1;
      chk("arst_now", {27'd0, hilo_we, stall, busy, 2'd0, hi_o, lo_o} , 96'd0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b1; valid = 1'b0; op = 3'd0;
      do_op("multu_post_rst", 3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 33);

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         valid   = ($urandom_range(0, 3) != 0);
         op      = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: rs_data = 32'h8000_0000;
            1: rs_data = 32'hFFFF_FFFF;
            default: rs_data = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rt_data = 32'd0;
            1: rt_data = 32'hFFFF_FFFF;
            2: rt_data = 32'($urandom_range(1, 15));
            default: rt_data = $urandom;
         endcase
         hi_cur  = $urandom;
         lo_cur  = $urandom;
         flush   = ($urandom_range(0, 39) == 0);
      end
      @(posedge clk); #1; valid = 1'b0; flush = 1'b0; op = 3'd0;
      repeat (40) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
